// File: rtl/dffrs_seq_pkg.sv
// Shared types and constants for the DFFRS preset sequencer.
package dffrs_seq_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    PULSE,
    RECOVER,
    DONE
  } seq_state_t;

endpackage

// File: rtl/dffrs_seq_cnt.sv
// Loadable down-counter that times the SN/RN pulse and the recovery window.
module dffrs_seq_cnt
  import dffrs_seq_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt;

  // Holding at zero keeps a stray decrement from wrapping to 15.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/dffrs_preset_seq.sv
// Drives the async SN/RN pins of a DFFRS bank to load a preset pattern,
// with pulse and recovery times counted in CK cycles and the bank clock gated meanwhile.
module dffrs_preset_seq
  import dffrs_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PULSE_CYC = 2,
  parameter int RECOV_CYC = 2
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             init_req,
  input  logic [WIDTH-1:0] init_val,
  input  logic             abort_clr,
  output logic             init_ack,
  output logic             busy,
  output logic             bank_ce,
  output logic [WIDTH-1:0] bank_sn,
  output logic [WIDTH-1:0] bank_rn
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC);
  localparam logic [CNT_W-1:0] RECOV_LD = CNT_W'(RECOV_CYC);

  if ((PULSE_CYC < 1) || (PULSE_CYC > 15)) begin : g_pulse_range
    $error("PULSE_CYC must be in 1..15");
  end
  if ((RECOV_CYC < 1) || (RECOV_CYC > 15)) begin : g_recov_range
    $error("RECOV_CYC must be in 1..15");
  end

  seq_state_t       state, nstate;
  logic [WIDTH-1:0] pat, npat;
  logic             postrst, npostrst;
  logic             relwait;
  logic             cnt_load, cnt_dec, is_one;
  logic [CNT_W-1:0] cnt_val;
  logic             ack_d, busy_d, ce_d;
  logic [WIDTH-1:0] sn_d, rn_d;

  dffrs_seq_cnt #(
    .RST_VAL(RECOV_LD)
  ) u_cnt (
    .CK      (CK),
    .RN      (RN),
    .load    (cnt_load),
    .load_val(cnt_val),
    .dec     (cnt_dec),
    .is_one  (is_one)
  );

  // relwait spends the first edge after reset release just lifting bank_rn,
  // so the full recovery window is still counted afterwards.
  always_comb begin
    nstate   = state;
    npat     = pat;
    npostrst = postrst;
    cnt_load = 1'b0;
    cnt_val  = PULSE_LD;
    cnt_dec  = 1'b0;
    if (abort_clr && !((state == RECOVER) && postrst)) begin
      nstate   = PULSE;
      npat     = '0;
      npostrst = 1'b0;
      cnt_load = 1'b1;
      cnt_val  = PULSE_LD;
    end else begin
      case (state)
        IDLE: begin
          if (init_req) begin
            nstate = QUIESCE;
            npat   = init_val;
          end
        end
        QUIESCE: begin
          nstate   = PULSE;
          cnt_load = 1'b1;
          cnt_val  = PULSE_LD;
        end
        PULSE: begin
          if (is_one) begin
            nstate   = RECOVER;
            cnt_load = 1'b1;
            cnt_val  = RECOV_LD;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        RECOVER: begin
          if (!relwait) begin
            if (is_one) begin
              nstate = DONE;
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end
        DONE: begin
          nstate   = IDLE;
          npostrst = 1'b0;
        end
        default: nstate = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    ack_d  = 1'b0;
    busy_d = 1'b1;
    ce_d   = 1'b0;
    sn_d   = '1;
    rn_d   = '1;
    case (nstate)
      IDLE: begin
        busy_d = 1'b0;
        ce_d   = 1'b1;
      end
      PULSE: begin
        sn_d = ~npat;
        rn_d = npat;
      end
      DONE: begin
        ce_d  = 1'b1;
        ack_d = !npostrst;
      end
      default: ;
    endcase
  end

  // Reset clears the bank directly through RN while the clock stays gated.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state    <= RECOVER;
      pat      <= '0;
      postrst  <= 1'b1;
      relwait  <= 1'b1;
      init_ack <= 1'b0;
      busy     <= 1'b1;
      bank_ce  <= 1'b0;
      bank_sn  <= '1;
      bank_rn  <= '0;
    end else begin
      state    <= nstate;
      pat      <= npat;
      postrst  <= npostrst;
      relwait  <= 1'b0;
      init_ack <= ack_d;
      busy     <= busy_d;
      bank_ce  <= ce_d;
      bank_sn  <= sn_d;
      bank_rn  <= rn_d;
    end
  end

endmodule
